rr_mux_n: RTL
=============

Name: rr_mux_n

Overview:
- Parametrised N-channel registered multiplexer with per-channel valid/ready handshake. Replaces the fixed 4:1 combinational mux with hardware-chosen channel selection.
- Selection is round-robin or fixed-priority. One pipeline register sits on the output.
- Sits between several producer channels and one shared consumer, e.g. a shared bus or UART TX path.

Parameters:
- N_CH, 4: number of input channels, ≥2.
- DW, 8: data width per channel, ≥1.
- SELW, $clog2(N_CH): width of the channel-index output. Derived; never overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N_CH  bit i set = channel i presents a word.
- in_data  input  N_CH*DW  channel i data in bits [i*DW +: DW].
- in_ready  output  N_CH  bit i set = channel i word accepted this cycle.
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- out_valid  output  1  output register holds a word.
- out_data  output  DW  registered selected word.
- out_sel  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the word when out_valid is also set.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_sel=0, RR pointer last=N_CH-1 (so channel 0 is searched first).
- Any held word is discarded. in_ready is all-zero while rst=1.
- load = !out_valid | out_ready. Combinational; the output register may take a new word this cycle.
- Grant is one-hot and combinational from in_valid, mode, last.
  - mode=0: first set in_valid bit, searching indices last+1, last+2, … modulo N_CH.
  - mode=1: lowest-index set in_valid bit.
  - No in_valid set: grant=0.
- in_ready = grant & {N_CH{load}}. At most one bit is set. Never depends on the channel's own in_valid beyond the grant logic.
- Transfer on channel i: in_valid[i] & in_ready[i]. At that edge:
  - out_data <= in_data[i], out_sel <= i, out_valid <= 1.
  - last <= i. The pointer updates in both modes, so a mode switch resumes fairly.
- Consumer transfer: out_valid & out_ready. If no input transfer happens in the same cycle, out_valid <= 0. out_data and out_sel hold their values.
- Simultaneous consumer and input transfer: new word loads and out_valid stays 1. Full throughput is one word per clock.
- Stall: out_valid=1 & out_ready=0 means out_data and out_sel are stable, in_ready=0, and last is unchanged.
- Latency: one cycle from input transfer to out_valid.
- Ordering: per-channel order is preserved. No word is dropped or duplicated except at reset.
- mode change: takes effect on the next grant evaluation. It never alters a held word.
- in_valid deasserted before grant: no side effects. Arbitration re-evaluates every cycle. Producers are expected to hold valid until ready, but the block does not depend on it.
- Wrap-around: pointer search wraps N_CH-1 → 0.
- Non-power-of-two N_CH: indices ≥ N_CH are never produced.

Decomposition:
- Shared package mux_pkg: rr_mode_e enum (RR=0, FIXED=1) and a clog2-safe SELW helper.
- One natural sub-module: rr_arbiter_n. Parameter N_CH; inputs req, last, mode; output one-hot grant and its index.
- Datapath register and handshake stay in rr_mux_n.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all in_valid=1. Require out_valid=0, out_data=0, out_sel=0, in_ready=0. After release, the first grant is channel 0.
- RR fairness: N_CH=4, mode=0, in_valid=4'b1111 with in_data[i]=8'hA0+i, out_ready=1. Require out_sel sequence 0,1,2,3,0… and out_data A0,A1,A2,A3 on consecutive cycles, one word per clock.
- Fixed priority: mode=1, in_valid=4'b1010. Require out_sel=1 repeatedly while bit1 is set. Clear bit1: next out_sel=3.
- Backpressure: out_ready=0 for 3 cycles after out_valid rises with out_data=8'h5C. Require out_data=5C, out_sel stable, in_ready=0 throughout. Raise out_ready: the next word loads the same cycle the held word drains.
- Sparse requests and wrap: last=3, in_valid=4'b0100. Require grant to channel 2. Then in_valid=4'b0011 gives channel 0 next. Idle with out_ready=1 gives out_valid=0 the cycle after the drain.
- Mid-operation reset: assert rst while out_valid=1, out_ready=0. Require the held word to vanish (out_valid=0 next cycle) and the pointer to return so channel 0 wins first after release.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin output multiplexer.
package mux_pkg;

   typedef enum logic {RR = 1'b0, FIXED = 1'b1} rr_mode_e;

   // Index width that stays at least one bit wide for tiny channel counts.
   function automatic int sel_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// One-hot grant from a request vector: round-robin after `last` or lowest index first.
module rr_arbiter_n
   import mux_pkg::*;
#(
   parameter  int N_CH = 4,
   localparam int SELW = sel_w(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [SELW-1:0] last,
   input  rr_mode_e        mode,
   output logic [N_CH-1:0] grant,
   output logic [SELW-1:0] idx
);

   logic            found;
   logic [SELW-1:0] cand;

   // Walk candidates in priority order; the modulo keeps indices below N_CH.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (mode == FIXED) cand = SELW'(k);
         else               cand = SELW'((int'(last) + 1 + k) % N_CH);
         if (!found && req[cand]) begin
            found       = 1'b1;
            idx         = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_mux_n.sv
// N-channel registered mux: arbitrated valid/ready inputs feed one output register.
module rr_mux_n
   import mux_pkg::*;
#(
   parameter  int N_CH = 4,
   parameter  int DW   = 8,
   localparam int SELW = sel_w(N_CH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_CH-1:0]      in_valid,
   input  logic [N_CH*DW-1:0]   in_data,
   output logic [N_CH-1:0]      in_ready,
   input  logic                 mode,
   output logic                 out_valid,
   output logic [DW-1:0]        out_data,
   output logic [SELW-1:0]      out_sel,
   input  logic                 out_ready
);

   logic [SELW-1:0] last;
   logic [N_CH-1:0] grant;
   logic [SELW-1:0] gidx;
   logic            load;
   logic            xfer;

   rr_arbiter_n #(.N_CH(N_CH)) u_arb (
      .req   (in_valid),
      .last  (last),
      .mode  (rr_mode_e'(mode)),
      .grant (grant),
      .idx   (gidx)
   );

   assign load     = !out_valid || out_ready;
   assign in_ready = rst ? '0 : (grant & {N_CH{load}});
   // Grant is already a subset of in_valid, so any ready bit is a transfer.
   assign xfer     = |in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         last      <= SELW'(N_CH - 1);
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= in_data[int'(gidx)*DW +: DW];
         out_sel   <= gidx;
         last      <= gidx;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
